fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Multicycle-CPU fetch stage: PC, instruction register, ALUOut and MDR holding
// registers, branch-taken pulse and an instruction-load counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          JUMP_HI  = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IRwrite,
    input  logic        PCwrite,
    input  logic        PCwritecond,
    input  logic        branch,
    input  logic [1:0]  PCsource,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [15:0] imm,
    output logic [31:0] alu_out,
    output logic [31:0] mdr,
    output logic        branch_taken,
    output logic [31:0] instr_count
);

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] alu_out_r;
    logic [31:0] mdr_r;
    logic        branch_taken_r;
    logic [31:0] instr_count_r;

    logic        taken_s;
    logic        pc_en_s;
    logic [31:0] jump_target_s;
    logic [31:0] next_pc_s;

    // Branch decision and PC write enable
    always_comb begin
        taken_s = 1'b0;
        if (PCwritecond) begin
            taken_s = branch ? alu_zero : ~alu_zero;
        end else begin
            taken_s = 1'b0;
        end
        pc_en_s = PCwrite | taken_s;
    end

    // Next-PC selection; the jump target keeps the upper PC bits from before the edge
    always_comb begin
        jump_target_s = {pc_r[31:32-JUMP_HI], instr_r[31-JUMP_HI:0]};
        next_pc_s     = pc_r;
        case (PCsource)
            2'b00:   next_pc_s = alu_result;
            2'b01:   next_pc_s = alu_out_r;
            2'b10:   next_pc_s = jump_target_s;
            2'b11:   next_pc_s = pc_r;
            default: next_pc_s = pc_r;
        endcase
    end

    // Program counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else if (pc_en_s) begin
            pc_r <= next_pc_s;
        end
    end

    // Instruction register and load counter (counter wraps silently)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_r       <= 32'h0000_0000;
            instr_count_r <= 32'h0000_0000;
        end else if (IRwrite) begin
            instr_r       <= mem_rdata;
            instr_count_r <= instr_count_r + 32'd1;
        end
    end

    // Free-running holding registers and the one-cycle branch pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_out_r      <= 32'h0000_0000;
            mdr_r          <= 32'h0000_0000;
            branch_taken_r <= 1'b0;
        end else begin
            alu_out_r      <= alu_result;
            mdr_r          <= mem_rdata;
            branch_taken_r <= taken_s;
        end
    end

    assign pc           = pc_r;
    assign instr        = instr_r;
    assign opcode       = instr_r[31:26];
    assign imm          = instr_r[15:0];
    assign alu_out      = alu_out_r;
    assign mdr          = mdr_r;
    assign branch_taken = branch_taken_r;
    assign instr_count  = instr_count_r;

endmodule
